// File: rtl/regfile_access_ctrl.sv
// Purpose: initiator-side controller for a 2-read/1-write register file with a
// one-cycle registered read. Sequences RA/RB for an operand fetch, captures the
// read buses (with same-edge write bypass and R0 forcing), and holds the operands
// until the consumer accepts them. The writeback path forwards requests straight
// to the file and suppresses writes to R0.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready/req_rs1/2 operand-fetch request
//   op_valid/op_ready/op_a/op_b   captured operands, held until op_ready
//   wb_valid/wb_rd/wb_data        writeback request (never back-pressured)
//   flush                         abort an in-flight fetch
//   rf_en/rf_ra/rf_rb/rf_rw/rf_busw/rf_busa/rf_busb  register file port
module regfile_access_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              rf_en,
    output logic [ADDR_W-1:0] rf_ra,
    output logic [ADDR_W-1:0] rf_rb,
    output logic [ADDR_W-1:0] rf_rw,
    output logic [DATA_W-1:0] rf_busw,
    input  logic [DATA_W-1:0] rf_busa,
    input  logic [DATA_W-1:0] rf_busb
);

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] S_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] S_ISSUE   = 2'd1;
    localparam logic [ST_W-1:0] S_CAPTURE = 2'd2;
    localparam logic [ST_W-1:0] S_DONE    = 2'd3;

    logic [ST_W-1:0]   state_q, state_d;
    logic [ADDR_W-1:0] rs1_q, rs1_d;
    logic [ADDR_W-1:0] rs2_q, rs2_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              op_valid_q, op_valid_d;
    logic              byp_a_q, byp_a_d;
    logic              byp_b_q, byp_b_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;
    logic              wb_en;

    // Writeback path: combinational pass-through, R0 writes dropped
    assign wb_en   = wb_valid && (wb_rd != '0);
    assign rf_en   = wb_en;
    assign rf_rw   = wb_rd;
    assign rf_busw = wb_data;

    assign rf_ra     = rs1_q;
    assign rf_rb     = rs2_q;
    assign req_ready = (state_q == S_IDLE);
    assign op_valid  = op_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;

    // Next-state and datapath decode
    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        byp_a_d    = 1'b0;
        byp_b_d    = 1'b0;
        byp_data_d = byp_data_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    // File returns the old value on a same-edge write; remember the new one
                    byp_a_d    = wb_en && (wb_rd == rs1_q);
                    byp_b_d    = wb_en && (wb_rd == rs2_q);
                    byp_data_d = wb_data;
                    state_d    = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    // R0 forcing overrides both the bus and the bypass
                    if (rs1_q == '0)  op_a_d = '0;
                    else if (byp_a_q) op_a_d = byp_data_q;
                    else              op_a_d = rf_busa;
                    if (rs2_q == '0)  op_b_d = '0;
                    else if (byp_b_q) op_b_d = byp_data_q;
                    else              op_b_d = rf_busb;
                    op_valid_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                // flush and op_ready both release the operands and return to IDLE
                if (flush || op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                op_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            byp_a_q    <= 1'b0;
            byp_b_q    <= 1'b0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            byp_a_q    <= byp_a_d;
            byp_b_q    <= byp_b_d;
            byp_data_q <= byp_data_d;
        end
    end

endmodule
